// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the RV64M MUL/DIV/REM family.
// Shift-add multiply and restoring divide, UNROLL iteration bits per clock.
module mdu_iter #(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg, op_next;
  logic              neg_q_reg, neg_q_next;
  logic              neg_r_reg, neg_r_next;
  logic [XLEN-1:0]   opnd_reg, opnd_next;
  logic [2*XLEN-1:0] acc_reg, acc_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [XLEN-1:0]   result_reg, result_next;
  logic              div_zero_reg, div_zero_next;

  logic            a_signed, b_signed, a_neg, b_neg, b_zero, sdiv_ovf;
  logic [XLEN-1:0] a_abs, b_abs, special_res;

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && a[XLEN-1];
    b_neg    = b_signed && b[XLEN-1];
    a_abs    = a_neg ? -a : a;
    b_abs    = b_neg ? -b : b;
    b_zero   = (b == '0);
    sdiv_ovf = op[2] && !op[0] && (a == MIN_NEG) && (&b);
    // op[1] separates REM/REMU from DIV/DIVU among the divide opcodes
    if (b_zero) special_res = op[1] ? a : '1;
    else        special_res = op[1] ? '0 : a;
  end

  // acc_reg holds {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
  logic              div_mode;
  logic [2*XLEN-1:0] stage_acc [UNROLL+1];

  assign div_mode     = op_reg[2];
  assign stage_acc[0] = acc_reg;

  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
      logic [XLEN:0] mul_sum;
      logic [XLEN:0] div_shift;
      logic [XLEN:0] div_trial;

      assign mul_sum   = {1'b0, stage_acc[gi][2*XLEN-1:XLEN]}
                       + (stage_acc[gi][0] ? {1'b0, opnd_reg} : '0);
      assign div_shift = stage_acc[gi][2*XLEN-1:XLEN-1];
      assign div_trial = div_shift - {1'b0, opnd_reg};

      assign stage_acc[gi+1] = !div_mode ? {mul_sum, stage_acc[gi][XLEN-1:1]} :
                               div_trial[XLEN] ?
                                 {div_shift[XLEN-1:0], stage_acc[gi][XLEN-2:0], 1'b0} :
                                 {div_trial[XLEN-1:0], stage_acc[gi][XLEN-2:0], 1'b1};
    end
  endgenerate

  logic [2*XLEN-1:0] fin, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  always_comb begin
    fin      = stage_acc[UNROLL];
    prod_fix = neg_q_reg ? -fin : fin;
    quo_fix  = neg_q_reg ? -fin[XLEN-1:0] : fin[XLEN-1:0];
    rem_fix  = neg_r_reg ? -fin[2*XLEN-1:XLEN] : fin[2*XLEN-1:XLEN];
    case (op_reg)
      OP_MUL:                       final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quo_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    opnd_next     = opnd_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    result_next   = result_reg;
    div_zero_next = div_zero_reg;

    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_next    = op;
            neg_q_next = a_neg ^ b_neg;
            neg_r_next = a_neg;
            opnd_next  = op[2] ? b_abs : a_abs;
            acc_next   = op[2] ? {{XLEN{1'b0}}, a_abs} : {{XLEN{1'b0}}, b_abs};
            cnt_next   = CW'(STEPS);
            if (op[2] && (b_zero || sdiv_ovf)) begin
              state_next    = DONE;
              result_next   = special_res;
              div_zero_next = b_zero;
            end else begin
              state_next    = CALC;
              div_zero_next = 1'b0;
            end
          end
        end
        CALC: begin
          acc_next = stage_acc[UNROLL];
          cnt_next = cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_next  = DONE;
            result_next = final_res;
          end
        end
        DONE: begin
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      result_reg   <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
      opnd_reg     <= opnd_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      result_reg   <= result_next;
      div_zero_reg <= div_zero_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: one instance with UNROLL=1, one with UNROLL=4.
// Expected results and latencies are queued at issue and checked by a monitor.
module tb_mdu_iter;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        in_valid_s  [2];
  logic        in_ready_s  [2];
  logic [2:0]  op_s        [2];
  logic [63:0] a_s         [2];
  logic [63:0] b_s         [2];
  logic        flush_s     [2];
  logic        out_valid_s [2];
  logic        out_ready_s [2];
  logic [63:0] result_s    [2];
  logic        div_zero_s  [2];

  mdu_iter #(.XLEN(64), .UNROLL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .op(op_s[0]), .a(a_s[0]), .b(b_s[0]), .flush(flush_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .result(result_s[0]), .div_zero(div_zero_s[0])
  );

  mdu_iter #(.XLEN(64), .UNROLL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .op(op_s[1]), .a(a_s[1]), .b(b_s[1]), .flush(flush_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .result(result_s[1]), .div_zero(div_zero_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          lat;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitor: pop on the first cycle of each out_valid burst, then check the held result.
  bit   held   [2];
  bit   cur_ok [2];
  exp_t cur    [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n && out_valid_s[d]) begin
        if (!held[d]) begin
          held[d] = 1'b1;
          cur_ok[d] = 1'b0;
          n_cmp++;
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_bad++;
            $display("FAIL unexpected_output dut%0d: got out_valid=1 result=%h, required no output",
                     d, result_s[d]);
          end else begin
            if (d == 0) cur[d] = q0.pop_front();
            else        cur[d] = q1.pop_front();
            cur_ok[d] = 1'b1;
            $display("txn dut%0d %s: result=%h div_zero=%b latency=%0d",
                     d, cur[d].name, result_s[d], div_zero_s[d], cyc + 1 - cur[d].acc_cyc);
            chk({cur[d].name, "_result"}, result_s[d], cur[d].res);
            chk({cur[d].name, "_div_zero"}, 64'(div_zero_s[d]), 64'(cur[d].dz));
            chk({cur[d].name, "_latency"}, 64'(cyc + 1 - cur[d].acc_cyc), 64'(cur[d].lat));
          end
        end else if (cur_ok[d]) begin
          chk({cur[d].name, "_held_result"}, result_s[d], cur[d].res);
        end
        if (cur_ok[d]) chk({cur[d].name, "_in_ready_done"}, 64'(in_ready_s[d]), 64'd0);
      end else begin
        held[d] = 1'b0;
      end
    end
  end

  task automatic issue(input int d, input logic [2:0] o, input logic [63:0] av,
                       input logic [63:0] bv, input logic [63:0] er, input logic ed,
                       input bit special, input bit push, input string nm);
    int   guard = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready_s[d] && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready_s[d]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept_timeout: got in_ready=0, required 1", nm);
      return;
    end
    in_valid_s[d] = 1'b1;
    op_s[d] = o;
    a_s[d]  = av;
    b_s[d]  = bv;
    if (push) begin
      e.res = er;
      e.dz = ed;
      e.lat = special ? 1 : 1 + 64 / ((d == 0) ? 1 : 4);
      e.acc_cyc = cyc + 1;
      e.name = nm;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble request inputs: only values sampled at acceptance may matter.
    in_valid_s[d] = 1'b0;
    op_s[d] = 3'($urandom);
    a_s[d]  = {$urandom, $urandom};
    b_s[d]  = {$urandom, $urandom};
  endtask

  task automatic drain();
    int guard = 0;
    while (guard < 500 && !(q0.size() == 0 && q1.size() == 0 && in_ready_s[0] && in_ready_s[1])) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid_s[d] = 1'b0;
      op_s[d] = '0;
      a_s[d] = '0;
      b_s[d] = '0;
      flush_s[d] = 1'b0;
      out_ready_s[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_in_ready", 64'(in_ready_s[d]), 64'd1);
      chk("reset_out_valid", 64'(out_valid_s[d]), 64'd0);
      chk("reset_result", result_s[d], 64'd0);
      chk("reset_div_zero", 64'(div_zero_s[d]), 64'd0);
    end
    rst_n = 1'b1;

    // Multiply variants
    issue(0, MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 0, 1, "mul_7_m3");
    issue(0, MULHU,  ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0, 1, "mulhu_ones");
    issue(0, MULH,   ONES, ONES, 64'd0, 1'b0, 0, 1, "mulh_ones");
    issue(0, MULHSU, ONES, 64'd2, ONES, 1'b0, 0, 1, "mulhsu_m1_2");
    issue(0, MULH,   MINV, 64'd2, ONES, 1'b0, 0, 1, "mulh_min_2");
    // Divide variants
    issue(0, DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0, 1, "div_m7_2");
    issue(0, REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 1'b0, 0, 1, "rem_m7_2");
    issue(0, DIVU, 64'd7, 64'd2, 64'd3, 1'b0, 0, 1, "divu_7_2");
    issue(0, REMU, 64'd7, 64'd2, 64'd1, 1'b0, 0, 1, "remu_7_2");
    // Special divides
    issue(0, DIV,  64'd5, 64'd0, ONES, 1'b1, 1, 1, "div_by_zero");
    issue(0, REM,  64'd5, 64'd0, 64'd5, 1'b1, 1, 1, "rem_by_zero");
    issue(0, DIVU, 64'd9, 64'd0, ONES, 1'b1, 1, 1, "divu_by_zero");
    issue(0, DIV,  MINV, ONES, MINV, 1'b0, 1, 1, "div_overflow");
    issue(0, REM,  MINV, ONES, 64'd0, 1'b0, 1, 1, "rem_overflow");
    drain();

    // Back-pressure: hold DONE for 10 cycles with a request pending
    out_ready_s[0] = 1'b0;
    issue(0, MULHU, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0, 1, "hold_mulhu");
    begin
      int guard = 0;
      while (!out_valid_s[0] && guard < 200) begin
        @(negedge clk);
        guard++;
      end
    end
    chk("hold_reached_done", 64'(out_valid_s[0]), 64'd1);
    in_valid_s[0] = 1'b1;
    op_s[0] = MUL;
    a_s[0] = 64'd2;
    b_s[0] = 64'd3;
    repeat (10) @(negedge clk);
    out_ready_s[0] = 1'b1;
    issue(0, MUL, 64'd2, 64'd3, 64'd6, 1'b0, 0, 1, "after_hold_mul");
    drain();

    // Flush in CALC
    issue(0, DIV, 64'd100, 64'd7, 64'd0, 1'b0, 0, 0, "flushed_div");
    repeat (19) @(negedge clk);
    flush_s[0] = 1'b1;
    @(negedge clk);
    flush_s[0] = 1'b0;
    chk("flush_in_ready", 64'(in_ready_s[0]), 64'd1);
    chk("flush_out_valid", 64'(out_valid_s[0]), 64'd0);
    repeat (80) @(negedge clk);

    // Flush together with a request in IDLE: not accepted
    in_valid_s[0] = 1'b1;
    flush_s[0] = 1'b1;
    op_s[0] = MUL;
    a_s[0] = 64'd1;
    b_s[0] = 64'd1;
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    flush_s[0] = 1'b0;
    chk("flush_idle_not_accepted", 64'(in_ready_s[0]), 64'd1);

    // Asynchronous reset mid-operation
    issue(0, MUL, 64'd11, 64'd13, 64'd0, 1'b0, 0, 0, "reset_mul");
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid_s[0]), 64'd0);
    chk("midreset_in_ready", 64'(in_ready_s[0]), 64'd1);
    chk("midreset_result", result_s[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    issue(0, MUL, 64'd3, 64'd4, 64'd12, 1'b0, 0, 1, "mul_3_4");
    drain();

    // UNROLL=4 instance
    issue(1, MUL,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 0, 1, "u4_mul_7_m3");
    issue(1, MULHU, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0, 1, "u4_mulhu_ones");
    issue(1, DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0, 1, "u4_div_m7_2");
    issue(1, REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 1'b0, 0, 1, "u4_rem_m7_2");
    issue(1, DIVU, 64'd7, 64'd2, 64'd3, 1'b0, 0, 1, "u4_divu_7_2");
    issue(1, REMU, 64'd7, 64'd2, 64'd1, 1'b0, 0, 1, "u4_remu_7_2");
    issue(1, DIV,  64'd5, 64'd0, ONES, 1'b1, 1, 1, "u4_div_by_zero");
    drain();
    repeat (3) @(negedge clk);

    chk("queue0_empty", 64'(q0.size()), 64'd0);
    chk("queue1_empty", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
